reg_pipe_ce: RTL and testbench
==============================

REG_PIPE_CE -- requirements
Module: reg_pipe_ce

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 Parameter INIT, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Port RESET  input  1  reset; synchronous, active-high.
REQ-006 Port CE  input  1  clock enable; low freezes all state except reset/flush.
REQ-007 Port FLUSH  input  1  synchronous discard of all in-flight items.
REQ-008 Port In0  input  WIDTH  input data.
REQ-009 Port I_VALID  input  1  In0 valid.
REQ-010 Port I_READY  output  1  pipe accepts In0 this cycle.
REQ-011 Port Out0  output  WIDTH  data of last stage.
REQ-012 Port O_VALID  output  1  Out0 holds a valid item.
REQ-013 Port O_READY  input  1  downstream accepts Out0 this cycle.
REQ-014 Port COUNT  output  clog2(DEPTH+1)  number of valid items held.

Function
REQ-015 Each stage k (0 = input, DEPTH-1 = output) SHALL hold a data register d[k] and valid bit v[k].
REQ-016 Output transfer SHALL occur when O_VALID && O_READY && CE; input transfer when I_VALID && I_READY.
REQ-017 Stage k SHALL be able to load when !v[k] or stage k advances out (k=DEPTH-1: output transfer; else stage k+1 loads); bubbles collapse.
REQ-018 I_READY SHALL equal CE && !FLUSH && !RESET && (stage 0 able to load); combinational, no registered skid.
REQ-019 When stage k loads, d[k] SHALL take d[k-1] (k=0: In0) and v[k] SHALL take v[k-1] (k=0: input transfer); d[k] SHALL hold when v-in is 0.
REQ-020 O_VALID SHALL equal v[DEPTH-1]; Out0 SHALL equal d[DEPTH-1] whether or not valid.
REQ-021 Latency: an item accepted into an empty pipe with O_READY=1 SHALL appear at Out0 with O_VALID=1 exactly DEPTH cycles after acceptance.
REQ-022 Throughput: with I_VALID=O_READY=CE=1 continuously, one item per cycle SHALL transfer in and out.
REQ-023 With CE=0 no stage SHALL change, I_READY SHALL be 0, and no output transfer SHALL occur regardless of O_READY.
REQ-024 Full (COUNT=DEPTH) with O_READY=0: I_READY=0; full with output transfer: I_READY=1 same cycle (simultaneous in/out keeps COUNT).
REQ-025 COUNT SHALL be registered, +1 on input-only transfer, -1 on output-only, unchanged on both or neither; never exceeds DEPTH.
REQ-026 FLUSH=1 (RESET=0) SHALL clear all v[k] and COUNT next cycle irrespective of CE; d[k] retain; no input transfer; output transfer in that cycle SHALL still count as delivered.
REQ-027 Item order SHALL be preserved; no item duplicated or lost except by FLUSH/RESET.
REQ-028 DEPTH=1 SHALL behave as a single CE register with valid/ready handshake.

Reset
REQ-029 RESET SHALL take priority over FLUSH and CE.
REQ-030 After RESET: all v[k]=0, all d[k]=INIT, COUNT=0, O_VALID=0, Out0=INIT, I_READY=0 during reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight items in one cycle; first acceptance possible the cycle after RESET deasserts.

Structure
REQ-032 Package reg_pipe_pkg SHALL hold DEPTH_MAX=16, WIDTH_MAX=64, and the COUNT-width function.
REQ-033 One sub-module reg_pipe_stage (d/v register with load, CE, flush, reset, INIT) SHALL be instantiated DEPTH times via generate.

Verification
REQ-034 Reset: WIDTH=16, INIT=0xA5A5, assert RESET 2 cycles -> Out0=0xA5A5, O_VALID=0, COUNT=0.
REQ-035 Latency: DEPTH=4, push 0x1234 once into empty pipe, O_READY=1 -> O_VALID=1, Out0=0x1234 exactly 4 cycles later, COUNT back to 0.
REQ-036 Backpressure: O_READY=0, push 0x0001..0x0005 -> 4 accepted, I_READY=0 on 5th, COUNT=4; release O_READY -> 0x0001..0x0004 in order, then 0x0005 accepted.
REQ-037 CE stall: stream 0x0010..0x001F, drop CE for 3 cycles mid-stream -> no state change, I_READY=0, sequence resumes intact, no gaps/duplicates.
REQ-038 Flush and reset mid-flight: pipe with COUNT=3, FLUSH 1 cycle with CE=0 -> COUNT=0, O_VALID=0; refill, RESET 1 cycle -> d=INIT, COUNT=0.
REQ-039 Random: 10000 cycles random I_VALID/O_READY/CE, DEPTH in {1,4,16} -> scoreboard order match, COUNT matches model.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared limits and helpers for the clock-enabled register pipe.
package reg_pipe_pkg;

  localparam int DEPTH_MAX = 16;
  localparam int WIDTH_MAX = 64;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipe stage: data register plus valid bit.
// Data holds whenever a bubble is loaded, so only valid items overwrite it.
module reg_pipe_stage #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] d_prev,
  input  logic             v_prev,
  output logic [WIDTH-1:0] d,
  output logic             v
);

  // Reset beats flush beats a clock-enabled load.
  always_ff @(posedge clk) begin
    if (reset) begin
      d <= INIT;
      v <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ce && load) begin
      v <= v_prev;
      if (v_prev) d <= d_prev;
    end
  end

endmodule

// File: rtl/reg_pipe_ce.sv
// Bubble-collapsing register pipe with valid/ready handshake, clock enable
// and synchronous flush. A stage loads when it is empty or its item moves
// on, so ready ripples back combinationally from the output.
module reg_pipe_ce
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            CE,
  input  logic                            FLUSH,
  input  logic [WIDTH-1:0]                In0,
  input  logic                            I_VALID,
  output logic                            I_READY,
  output logic [WIDTH-1:0]                Out0,
  output logic                            O_VALID,
  input  logic                            O_READY,
  output logic [count_width(DEPTH)-1:0]   COUNT
);

  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] load;
  logic             out_xfer;
  logic             in_xfer;

  assign out_xfer = v[DEPTH-1] && O_READY && CE;

  // Load permission ripples from the output stage back toward the input.
  always_comb begin
    load = '0;
    load[DEPTH-1] = !v[DEPTH-1] || out_xfer;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      load[k] = !v[k] || load[k+1];
    end
  end

  assign I_READY = CE && !FLUSH && !RESET && load[0];
  assign in_xfer = I_VALID && I_READY;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_prev;
    logic             v_prev;

    if (k == 0) begin : g_first
      assign d_prev = In0;
      assign v_prev = in_xfer;
    end else begin : g_next
      assign d_prev = d[k-1];
      assign v_prev = v[k-1];
    end

    reg_pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk    (CLK),
      .reset  (RESET),
      .flush  (FLUSH),
      .ce     (CE),
      .load   (load[k]),
      .d_prev (d_prev),
      .v_prev (v_prev),
      .d      (d[k]),
      .v      (v[k])
    );
  end

  assign Out0    = d[DEPTH-1];
  assign O_VALID = v[DEPTH-1];

  // Occupancy tracks transfers; simultaneous in and out leaves it unchanged.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      COUNT <= '0;
    end else if (in_xfer && !out_xfer) begin
      COUNT <= COUNT + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      COUNT <= COUNT - CW'(1);
    end
  end

endmodule

// File: tb/tb_reg_pipe_ce.sv
// Bench for reg_pipe_ce: three depths share one stimulus stream; each has a
// FIFO scoreboard checking order, COUNT and I_READY every cycle, plus
// directed checks against the DEPTH=4 instance.
module tb_reg_pipe_ce;

  localparam logic [15:0] INIT_V = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset, ce, flush, i_valid, o_ready;
  logic [15:0] in0;
  logic        mon_en = 1'b0;

  logic [15:0] out_a [3];
  logic        ov_a  [3];
  logic        ir_a  [3];
  logic [4:0]  cnt_a [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int D  = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
    localparam int CW = $clog2(D + 1);

    logic [15:0]   out0;
    logic          ov, ir, oxf, exp_ir;
    logic [CW-1:0] cnt;
    logic [15:0]   q [$];
    int            mcnt = 0;

    reg_pipe_ce #(
      .WIDTH (16),
      .DEPTH (D),
      .INIT  (INIT_V)
    ) u_dut (
      .CLK     (clk),
      .RESET   (reset),
      .CE      (ce),
      .FLUSH   (flush),
      .In0     (in0),
      .I_VALID (i_valid),
      .I_READY (ir),
      .Out0    (out0),
      .O_VALID (ov),
      .O_READY (o_ready),
      .COUNT   (cnt)
    );

    assign out_a[gi] = out0;
    assign ov_a[gi]  = ov;
    assign ir_a[gi]  = ir;
    assign cnt_a[gi] = 5'(cnt);

    // Scoreboard: sample handshakes mid-cycle, predict state after next edge.
    always @(negedge clk) begin
      if (mon_en) begin
        oxf    = ov && o_ready && ce;
        exp_ir = ce && !flush && !reset && ((mcnt < D) || oxf);
        chk($sformatf("count_d%0d", D), 64'(cnt), 64'(mcnt));
        chk($sformatf("i_ready_d%0d", D), 64'(ir), 64'(exp_ir));
        if (q.size() == 0) chk($sformatf("ov_empty_d%0d", D), 64'(ov), 64'(0));
        else if (oxf) chk($sformatf("order_d%0d", D), 64'(out0), 64'(q.pop_front()));
        if (i_valid && ir) q.push_back(in0);
        if (reset || flush) begin
          q.delete();
          mcnt = 0;
        end else begin
          mcnt = q.size();
        end
      end
    end
  end

  logic [15:0] idx, exp_o, fr_out;
  logic [4:0]  fr_cnt;
  logic        fr_ov;
  int          lat;

  initial begin
    reset = 1'b1; ce = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b1; in0 = '0;

    // Reset
    tick();
    tick();
    chk("rst_out0",   64'(out_a[0]), 64'(INIT_V));
    chk("rst_ov",     64'(ov_a[0]),  64'(0));
    chk("rst_count",  64'(cnt_a[0]), 64'(0));
    chk("rst_iready", 64'(ir_a[0]),  64'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    #1;

    // Latency through an empty pipe
    i_valid = 1'b1; in0 = 16'h1234; o_ready = 1'b1;
    #1;
    chk("lat_iready", 64'(ir_a[0]), 64'(1));
    tick();
    i_valid = 1'b0;
    lat = 1;
    #1;
    while (!ov_a[0] && lat < 20) begin
      tick();
      lat++;
    end
    chk("lat_cycles", 64'(lat), 64'(4));
    chk("lat_out0",   64'(out_a[0]), 64'(16'h1234));
    tick();
    chk("lat_count",  64'(cnt_a[0]), 64'(0));

    // Backpressure: fill, block the 5th, release
    o_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      i_valid = 1'b1; in0 = 16'(i);
      #1;
      chk($sformatf("bp_iready_%0d", i), 64'(ir_a[0]), 64'(i < 5));
      if (i < 5) tick();
    end
    chk("bp_count_full", 64'(cnt_a[0]), 64'(4));
    tick();
    chk("bp_hold_iready", 64'(ir_a[0]), 64'(0));
    o_ready = 1'b1;
    #1;
    chk("bp_full_xfer_iready", 64'(ir_a[0]), 64'(1));
    chk("bp_out_1", 64'(out_a[0]), 64'(1));
    tick();
    i_valid = 1'b0;
    #1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("bp_ov_%0d", k),  64'(ov_a[0]),  64'(1));
      chk($sformatf("bp_out_%0d", k), 64'(out_a[0]), 64'(k));
      tick();
    end
    chk("bp_count_empty", 64'(cnt_a[0]), 64'(0));

    // CE stall mid-stream
    idx = 16'h0010; exp_o = 16'h0010;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ce = !(cyc >= 5 && cyc < 8);
      i_valid = (idx <= 16'h001F);
      in0 = idx;
      o_ready = 1'b1;
      #1;
      if (cyc == 5) begin
        fr_out = out_a[0]; fr_cnt = cnt_a[0]; fr_ov = ov_a[0];
      end
      if (!ce) chk("stall_iready", 64'(ir_a[0]), 64'(0));
      if (cyc >= 6 && cyc <= 8) begin
        chk("stall_out0",  64'(out_a[0]), 64'(fr_out));
        chk("stall_count", 64'(cnt_a[0]), 64'(fr_cnt));
        chk("stall_ov",    64'(ov_a[0]),  64'(fr_ov));
      end
      if (ov_a[0] && ce) begin
        chk("stream_order", 64'(out_a[0]), 64'(exp_o));
        exp_o++;
      end
      if (i_valid && ir_a[0]) idx++;
      tick();
    end
    i_valid = 1'b0; ce = 1'b1;
    chk("stream_in_all",  64'(idx),   64'(16'h0020));
    chk("stream_out_all", 64'(exp_o), 64'(16'h0020));

    // Flush with CE low, then reset mid-flight
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; in0 = 16'(16'h00F0 + i);
      tick();
    end
    chk("fl_count_pre", 64'(cnt_a[0]), 64'(3));
    in0 = 16'h0BAD; ce = 1'b0; flush = 1'b1;
    #1;
    chk("fl_iready", 64'(ir_a[0]), 64'(0));
    tick();
    flush = 1'b0; ce = 1'b1; i_valid = 1'b0;
    #1;
    chk("fl_count", 64'(cnt_a[0]), 64'(0));
    chk("fl_ov",    64'(ov_a[0]),  64'(0));
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; in0 = 16'(16'h0C00 + i);
      tick();
    end
    chk("rf_count_pre", 64'(cnt_a[0]), 64'(3));
    i_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_out0",  64'(out_a[0]), 64'(INIT_V));
    chk("mrst_count", 64'(cnt_a[0]), 64'(0));
    chk("mrst_ov",    64'(ov_a[0]),  64'(0));

    // Random traffic on all three depths
    for (int c = 0; c < 10000; c++) begin
      ce      = ($urandom_range(3) != 0);
      i_valid = 1'($urandom_range(1));
      o_ready = 1'($urandom_range(1));
      in0     = 16'($urandom);
      tick();
    end

    // Drain
    ce = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    chk("drain_count_d4",  64'(cnt_a[0]), 64'(0));
    chk("drain_count_d1",  64'(cnt_a[1]), 64'(0));
    chk("drain_count_d16", 64'(cnt_a[2]), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
